// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of one memory slave; round-robin on ties, one idle bubble between owners.
// Optional strobe watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_stall_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_stall_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_owner_q, last_owner_d;  // 0 = m0 served last, 1 = m1
    logic   own_m0, own_m1;
    logic   timeout;

    assign own_m0 = (state_q == GNT_M0);
    assign own_m1 = (state_q == GNT_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last_owner_q) begin
                        state_d      = GNT_M0;
                        last_owner_d = 1'b0;
                    end else begin
                        state_d      = GNT_M1;
                        last_owner_d = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d      = GNT_M0;
                    last_owner_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d      = GNT_M1;
                    last_owner_d = 1'b1;
                end
            end
            GNT_M0: if (!m0_cyc_i || timeout) state_d = IDLE;
            GNT_M1: if (!m1_cyc_i || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign timeout = (own_m0 || own_m1) && (cnt_q == TO_LIMIT);

    // Count only un-acked strobe cycles of the current owner; hold while stb is low.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || state_q == IDLE || s_ack_i)
            cnt_d = '0;
        else if (s_stb_o)
            cnt_d = cnt_q + 8'd1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
    assign timeout            = 1'b0;
`endif

    // Slave side is a plain mux of the owner; the watchdog cycle blanks it.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (own_m0 && !timeout) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (own_m1 && !timeout) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign m0_dat_o   = s_dat_i;
    assign m1_dat_o   = s_dat_i;
    assign m0_ack_o   = own_m0 && s_ack_i && !timeout;
    assign m1_ack_o   = own_m1 && s_ack_i && !timeout;
    assign m0_err_o   = own_m0 && timeout;
    assign m1_err_o   = own_m1 && timeout;
    assign m0_stall_o = m0_cyc_i && !own_m0 && !rst;
    assign m1_stall_o = m1_cyc_i && !own_m1 && !rst;
    assign grant_o    = {own_m1, own_m0};

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: stimulus pushes expected responses, a monitor pops them on each ack/err.
module tb_wb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cyc, stb, we;
    logic [9:0]  adr  [2];
    logic [31:0] wdat [2];
    wire  [31:0] m0_dat, m1_dat;
    wire  [1:0]  ack_o, err_o, stall_o, grant;
    wire         s_cyc_o, s_stb_o, s_we_o;
    wire  [9:0]  s_adr_o;
    wire  [31:0] s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic        ack_en;
    logic [31:0] mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic        chk;
        logic [31:0] dat;
    } exp_t;
    exp_t exp_q[$];

    wb_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]),
        .m0_dat_o(m0_dat), .m0_ack_o(ack_o[0]), .m0_err_o(err_o[0]), .m0_stall_o(stall_o[0]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]),
        .m1_dat_o(m1_dat), .m1_ack_o(ack_o[1]), .m1_err_o(err_o[1]), .m1_stall_o(stall_o[1]),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant)
    );

    always #5 clk = ~clk;

    // Zero-wait memory slave
    assign s_ack_i = ack_en & s_cyc_o & s_stb_o;
    assign s_dat_i = mem[s_adr_o];
    always @(posedge clk) if (s_ack_i && s_we_o) mem[s_adr_o] <= s_dat_o;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] a, input logic [1:0] e, input logic c, input logic [31:0] d);
        exp_t x;
        x.ack = a; x.err = e; x.chk = c; x.dat = d;
        exp_q.push_back(x);
    endtask

    task automatic xfer(input int m, input logic w, input logic [9:0] a, input logic [31:0] d);
        int n = 0;
        @(posedge clk); #1;
        cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w; adr[m] = a; wdat[m] = d;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack_o[m] | err_o[m]) && n < 200);
        if (!(ack_o[m] | err_o[m])) begin
            n_cmp++; n_bad++;
            $display("FAIL xfer_wait m%0d: no ack after %0d cycles, expected ack", m, n);
        end
        @(posedge clk); #1;
        cyc[m] = 1'b0; stb[m] = 1'b0; we[m] = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (ack_o != 2'b00 || err_o != 2'b00)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_resp: ack=%b err=%b, expected no response", ack_o, err_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_ack_err", {60'd0, ack_o, err_o}, {60'd0, e.ack, e.err});
                    if (e.chk) begin
                        chk("resp_m0_dat", {32'd0, m0_dat}, {32'd0, e.dat});
                        chk("resp_m1_dat", {32'd0, m1_dat}, {32'd0, e.dat});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]     = 32'hA5A5_0000;
        mem[10'h4] = 32'h1234_5678;
        mem[10'h10] = 32'h0BAD_F00D;
        rst = 1'b1; ack_en = 1'b1;
        cyc = 2'b11; stb = 2'b11; we = 2'b00;
        adr[0] = '0; adr[1] = '0; wdat[0] = '0; wdat[1] = '0;

        // Reset state, with both masters requesting
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_cyc_o, 1'b0);
        chk("rst_s_stb", s_stb_o, 1'b0);
        chk("rst_s_adr", s_adr_o, 10'h0);
        chk("rst_ack_err", {ack_o, err_o}, 4'b0000);
        chk("rst_stall", stall_o, 2'b00);
        chk("rst_dat_follow", m0_dat, 32'hA5A5_0000);
        cyc = 2'b00; stb = 2'b00;
        @(posedge clk); #1 rst = 1'b0;

        // First tie after reset: m0 wins, m1 stalls, one idle bubble
        push(2'b01, 2'b00, 1'b1, 32'h1234_5678);
        push(2'b10, 2'b00, 1'b1, 32'h0BAD_F00D);
        fork
            xfer(0, 1'b0, 10'h004, 32'h0);
            xfer(1, 1'b0, 10'h010, 32'h0);
            begin
                @(posedge clk); @(negedge clk);
                chk("tie_c0_grant", grant, 2'b00);
                chk("tie_c0_stall", stall_o, 2'b11);
                @(negedge clk);
                chk("tie_c1_grant", grant, 2'b01);
                chk("tie_c1_stall", stall_o, 2'b10);
                @(negedge clk);
                chk("tie_c2_grant", grant, 2'b01);
                @(negedge clk);
                chk("tie_c3_bubble", grant, 2'b00);
                chk("tie_c3_stall", stall_o, 2'b10);
                @(negedge clk);
                chk("tie_c4_grant", grant, 2'b10);
                chk("tie_c4_stall", stall_o, 2'b00);
            end
        join

        // Single write from m1
        push(2'b10, 2'b00, 1'b0, 32'h0);
        fork
            xfer(1, 1'b1, 10'h010, 32'hDEAD_BEEF);
            begin
                @(posedge clk); @(negedge clk);
                chk("wr_c0_grant", grant, 2'b00);
                @(negedge clk);
                chk("wr_grant", grant, 2'b10);
                chk("wr_s_ctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b111);
                chk("wr_s_adr", s_adr_o, 10'h010);
                chk("wr_s_dat", s_dat_o, 32'hDEAD_BEEF);
                chk("wr_stall", stall_o, 2'b00);
                chk("wr_ack", ack_o, 2'b10);
            end
        join

        // Read routing to m0, then readback of the write via m1
        push(2'b01, 2'b00, 1'b1, 32'h1234_5678);
        xfer(0, 1'b0, 10'h004, 32'h0);
        push(2'b10, 2'b00, 1'b1, 32'hDEAD_BEEF);
        xfer(1, 1'b0, 10'h010, 32'h0);

        // Continuous contention: strict alternation starting with m0
        for (int i = 0; i < 3; i++) begin
            push(2'b01, 2'b00, 1'b1, 32'h1234_5678);
            push(2'b10, 2'b00, 1'b1, 32'hDEAD_BEEF);
        end
        fork
            repeat (3) xfer(0, 1'b0, 10'h004, 32'h0);
            repeat (3) xfer(1, 1'b0, 10'h010, 32'h0);
        join

        // Slave never acks m1
        ack_en = 1'b0;
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 10'h020;
        @(negedge clk); @(negedge clk);
        chk("to_grant", grant, 2'b10);
`ifdef WB_ARB_TIMEOUT_EN
        push(2'b00, 2'b10, 1'b0, 32'h0);
        repeat (14) @(negedge clk);
        chk("to_pre_err", err_o, 2'b00);
        @(negedge clk);
        chk("to_err", err_o, 2'b10);
        chk("to_s_cyc", {s_cyc_o, s_stb_o}, 2'b00);
        @(negedge clk);
        chk("to_idle", grant, 2'b00);
        chk("to_err_pulse", err_o, 2'b00);
        cyc[1] = 1'b0; stb[1] = 1'b0;
`else
        begin
            logic held = 1'b1;
            repeat (100) begin
                @(negedge clk);
                if (grant !== 2'b10 || err_o !== 2'b00) held = 1'b0;
            end
            chk("hold_100", held, 1'b1);
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk);
        chk("hold_release", grant, 2'b00);
`endif

        // Reset while m0 holds a strobe
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 10'h004;
        @(negedge clk); @(negedge clk);
        chk("mid_grant", {grant, s_cyc_o}, 3'b011);
        rst = 1'b1;
        #1;
        chk("mid_s_cyc", {s_cyc_o, s_stb_o}, 2'b00);
        chk("mid_grant0", grant, 2'b00);
        chk("mid_ack_err", {ack_o, err_o}, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0; cyc = 2'b00; stb = 2'b00; ack_en = 1'b1;

        push(2'b01, 2'b00, 1'b1, 32'h1234_5678);
        push(2'b10, 2'b00, 1'b1, 32'hDEAD_BEEF);
        fork
            xfer(0, 1'b0, 10'h004, 32'h0);
            xfer(1, 1'b0, 10'h010, 32'h0);
        join

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_mem_arbiter.md
WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, Wishbone data width.
REQ-002 Parameter ADDR_WIDTH, default 10, memory word-address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 15, maximum un-acked strobe cycles before abort (range 1..255).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 m0_cyc_i / m1_cyc_i  in  1  cycle request; m0 = core, m1 = UART bridge.
REQ-007 m0_stb_i / m1_stb_i  in  1  strobe.
REQ-008 m0_we_i / m1_we_i  in  1  write enable.
REQ-009 m0_adr_i / m1_adr_i  in  ADDR_WIDTH  word address.
REQ-010 m0_dat_i / m1_dat_i  in  DATA_WIDTH  write data.
REQ-011 m0_dat_o / m1_dat_o  out  DATA_WIDTH  read data, equal to s_dat_i.
REQ-012 m0_ack_o / m1_ack_o  out  1  acknowledge.
REQ-013 m0_err_o / m1_err_o  out  1  timeout abort pulse.
REQ-014 m0_stall_o / m1_stall_o  out  1  master requesting but not granted.
REQ-015 s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control.
REQ-016 s_adr_o  out  ADDR_WIDTH; s_dat_o  out  DATA_WIDTH  slave address, write data.
REQ-017 s_dat_i  in  DATA_WIDTH; s_ack_i  in  1  slave read data, acknowledge.
REQ-018 grant_o  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle.

Function
REQ-019 FSM states: IDLE, GNT_M0, GNT_M1; grant_o decodes the state.
REQ-020 IDLE: only m0_cyc_i high -> GNT_M0 next cycle; only m1_cyc_i high -> GNT_M1 next cycle; neither -> stay.
REQ-021 IDLE with both cyc high: grant the master not in the last_owner register (round-robin); last_owner updates on every grant.
REQ-022 Grant latency is exactly one cycle from cyc assertion in IDLE; no grant switch while a grant is held.
REQ-023 GNT_Mx: s_cyc/stb/we/adr/dat driven combinationally from master x; in IDLE all slave outputs are 0.
REQ-024 s_ack_i routed only to mx_ack_o of the owner; non-owner ack_o is 0.
REQ-025 GNT_Mx -> IDLE in the cycle mx_cyc_i is sampled low; the other master may be granted one cycle later (one idle bubble).
REQ-026 mx_stall_o = mx_cyc_i AND NOT (state == GNT_Mx), combinational.
REQ-027 m0_dat_o and m1_dat_o both equal s_dat_i; masters qualify data with ack.
REQ-028 A master dropping cyc_i while waiting in IDLE is simply not granted; no state retained.
REQ-029 Back-to-back requests from one master with the other idle: re-grant after the single IDLE bubble.

Reset
REQ-030 rst high forces IDLE, last_owner = m1 (m0 wins the first tie), timeout counter 0; all outputs 0 except dat_o, which follow s_dat_i.
REQ-031 rst asserted mid-transfer aborts immediately: s_cyc_o/s_stb_o drop in the same cycle, and no ack or err is issued.

Configuration
REQ-032 Macro WB_ARB_TIMEOUT_EN: when defined, an 8-bit counter increments each cycle in GNT_Mx while s_stb_o = 1 and s_ack_i = 0, and clears on ack or state change.
REQ-033 With WB_ARB_TIMEOUT_EN defined, a count reaching TIMEOUT_CYCLES causes:
- mx_err_o high for one cycle;
- slave outputs forced to 0 in that cycle;
- FSM -> IDLE next cycle, last_owner = x.
REQ-034 Without WB_ARB_TIMEOUT_EN, there is no counter, m0_err_o = m1_err_o = 0 constant, and a grant is held indefinitely.

Verification
REQ-035 Single write: m1 cyc/stb/we at adr 0x010, dat 0xDEADBEEF -> grant_o = 10 one cycle later; slave sees the write; m1_ack_o follows s_ack_i; m0_stall_o = 0.
REQ-036 Tie after reset: m0 and m1 cyc asserted in the same cycle -> GNT_M0 first, m1_stall_o = 1 until m0 drops cyc; GNT_M1 after one IDLE bubble.
REQ-037 Repeated tie: both masters hold requests continuously, three transfers each -> grants alternate m0, m1, m0, m1, m0, m1.
REQ-038 Read routing: m0 read adr 0x004 with slave returning 0x12345678 and ack -> m0_dat_o = 0x12345678, m0_ack_o = 1, m1_ack_o = 0.
REQ-039 Timeout (macro defined, TIMEOUT_CYCLES = 15): slave never acks m1 strobe -> m1_err_o pulses one cycle, 15 cycles after grant; grant_o = 00 next cycle. Without the macro, grant is held for 100 cycles.
REQ-040 Reset mid-transfer: rst pulsed while GNT_M0 with stb high -> s_cyc_o = 0 in the same cycle, grant_o = 00, no ack or err; the first tie after release goes to m0.
